// File: rtl/conv_addr_gen.sv
// rtl/conv_addr_gen.sv - read-address walker for the 5x5 convolution MAC array
//
// Walks kx, ky, ox, oy, ch (innermost first) after a start pulse and presents
// one input-buffer address and one weight-buffer address per accepted tap,
// with neuron/plane boundary markers for the downstream counters.
//
// Optional feature macro: CONV_ADDR_CNT_EN adds the tap_count port.
//
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        one-cycle run request, honoured only when idle
//   stall        downstream hold; freezes the walk and all outputs
//   busy         high from the cycle after an accepted start until done
//   addr_valid   in_addr / w_addr / markers are valid this cycle
//   in_addr      (oy+ky)*IMG_W + (ox+kx)
//   w_addr       ch*K*K + ky*K + kx
//   neuron_last  final tap of an output pixel
//   plane_last   final tap of the final pixel of a plane
//   out_ch       output channel of the presented tap
//   done         one-cycle pulse after the final tap is accepted
//   tap_count    (CONV_ADDR_CNT_EN only) accepted taps since last start

module conv_addr_gen #(
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int K      = 5,
  parameter int N_CH   = 4,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stall,
  output logic              busy,
  output logic              addr_valid,
  output logic [ADDR_W-1:0] in_addr,
  output logic [ADDR_W-1:0] w_addr,
  output logic              neuron_last,
  output logic              plane_last,
  output logic [7:0]        out_ch,
  output logic              done
`ifdef CONV_ADDR_CNT_EN
  ,
  output logic [31:0]       tap_count
`endif
);

  localparam int OUT_W = IMG_W - K + 1;
  localparam int OUT_H = IMG_H - K + 1;
  localparam int KW = (K > 1) ? $clog2(K) : 1;
  localparam int OW = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int HW = (OUT_H > 1) ? $clog2(OUT_H) : 1;
  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t state;

  // Counters always hold the coordinates of the tap currently presented.
  logic [KW-1:0] kx, ky;
  logic [OW-1:0] ox;
  logic [HW-1:0] oy;
  logic [CW-1:0] ch;

  logic kx_max, ky_max, ox_max, oy_max, ch_max, last_tap;

  assign kx_max   = (kx == KW'(K - 1));
  assign ky_max   = (ky == KW'(K - 1));
  assign ox_max   = (ox == OW'(OUT_W - 1));
  assign oy_max   = (oy == HW'(OUT_H - 1));
  assign ch_max   = (ch == CW'(N_CH - 1));
  assign last_tap = kx_max && ky_max && ox_max && oy_max && ch_max;

  // Next tap coordinates: ripple-carry through the nested counters.
  logic [KW-1:0] nkx, nky;
  logic [OW-1:0] nox;
  logic [HW-1:0] noy;
  logic [CW-1:0] nch;

  always_comb begin
    nkx = kx;
    nky = ky;
    nox = ox;
    noy = oy;
    nch = ch;
    if (kx_max) begin
      nkx = '0;
      if (ky_max) begin
        nky = '0;
        if (ox_max) begin
          nox = '0;
          if (oy_max) begin
            noy = '0;
            nch = ch_max ? '0 : ch + CW'(1);
          end else begin
            noy = oy + HW'(1);
          end
        end else begin
          nox = ox + OW'(1);
        end
      end else begin
        nky = ky + KW'(1);
      end
    end else begin
      nkx = kx + KW'(1);
    end
  end

  // The tap about to be registered: all-zero when a run is being launched,
  // otherwise the successor of the current tap.
  logic          load;
  logic [KW-1:0] sel_kx, sel_ky;
  logic [OW-1:0] sel_ox;
  logic [HW-1:0] sel_oy;
  logic [CW-1:0] sel_ch;

  assign load   = (state == S_IDLE);
  assign sel_kx = load ? '0 : nkx;
  assign sel_ky = load ? '0 : nky;
  assign sel_ox = load ? '0 : nox;
  assign sel_oy = load ? '0 : noy;
  assign sel_ch = load ? '0 : nch;

  // Address arithmetic is done at 32 bits and truncated to ADDR_W.
  logic [31:0] in_sum, w_sum;
  logic        sel_nl, sel_pl;

  always_comb begin
    in_sum = (32'(sel_oy) + 32'(sel_ky)) * 32'(IMG_W) + 32'(sel_ox) + 32'(sel_kx);
    w_sum  = 32'(sel_ch) * 32'(K * K) + 32'(sel_ky) * 32'(K) + 32'(sel_kx);
    sel_nl = (sel_kx == KW'(K - 1)) && (sel_ky == KW'(K - 1));
    sel_pl = sel_nl && (sel_ox == OW'(OUT_W - 1)) && (sel_oy == HW'(OUT_H - 1));
  end

  logic accept;
  assign accept = (state == S_RUN) && !stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      kx          <= '0;
      ky          <= '0;
      ox          <= '0;
      oy          <= '0;
      ch          <= '0;
      busy        <= 1'b0;
      addr_valid  <= 1'b0;
      in_addr     <= '0;
      w_addr      <= '0;
      neuron_last <= 1'b0;
      plane_last  <= 1'b0;
      out_ch      <= '0;
      done        <= 1'b0;
`ifdef CONV_ADDR_CNT_EN
      tap_count   <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state       <= S_RUN;
            kx          <= '0;
            ky          <= '0;
            ox          <= '0;
            oy          <= '0;
            ch          <= '0;
            busy        <= 1'b1;
            addr_valid  <= 1'b1;
            in_addr     <= in_sum[ADDR_W-1:0];
            w_addr      <= w_sum[ADDR_W-1:0];
            neuron_last <= sel_nl;
            plane_last  <= sel_pl;
            out_ch      <= 8'(sel_ch);
`ifdef CONV_ADDR_CNT_EN
            tap_count   <= '0;
`endif
          end
        end

        S_RUN: begin
          if (accept) begin
`ifdef CONV_ADDR_CNT_EN
            tap_count <= tap_count + 32'd1;
`endif
            if (last_tap) begin
              // Addresses are left holding; only valid and markers drop.
              state       <= S_DONE;
              addr_valid  <= 1'b0;
              neuron_last <= 1'b0;
              plane_last  <= 1'b0;
              done        <= 1'b1;
            end else begin
              kx          <= nkx;
              ky          <= nky;
              ox          <= nox;
              oy          <= noy;
              ch          <= nch;
              in_addr     <= in_sum[ADDR_W-1:0];
              w_addr      <= w_sum[ADDR_W-1:0];
              neuron_last <= sel_nl;
              plane_last  <= sel_pl;
              out_ch      <= 8'(sel_ch);
            end
          end
        end

        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_addr_gen.sv
// tb/tb_conv_addr_gen.sv - self-checking bench for conv_addr_gen
module tb_conv_addr_gen;

  localparam int IMG_W  = 32;
  localparam int IMG_H  = 6;
  localparam int K      = 5;
  localparam int N_CH   = 4;
  localparam int ADDR_W = 16;
  localparam int OUT_W  = IMG_W - K + 1;
  localparam int OUT_H  = IMG_H - K + 1;
  localparam int TOTAL  = N_CH * OUT_H * OUT_W * K * K;
  localparam int NV     = 18;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              stall;
  logic              busy;
  logic              addr_valid;
  logic [ADDR_W-1:0] in_addr;
  logic [ADDR_W-1:0] w_addr;
  logic              neuron_last;
  logic              plane_last;
  logic [7:0]        out_ch;
  logic              done;
`ifdef CONV_ADDR_CNT_EN
  logic [31:0]       tap_count;
`endif

  conv_addr_gen #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .N_CH(N_CH), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
    .busy(busy), .addr_valid(addr_valid), .in_addr(in_addr), .w_addr(w_addr),
    .neuron_last(neuron_last), .plane_last(plane_last), .out_ch(out_ch),
    .done(done)
`ifdef CONV_ADDR_CNT_EN
    , .tap_count(tap_count)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int idx;
    int in_a;
    int w_a;
    bit nl;
    bit pl;
    int ch;
  } vec_t;

  vec_t vecs[NV];
  int   rec_in[TOTAL];
  int   rec_w[TOTAL];
  bit   rec_nl[TOTAL];
  bit   rec_pl[TOTAL];
  int   rec_ch[TOTAL];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pack(input int ia, input int wa, input bit nl, input bit pl,
                                       input int ch, input bit v, input bit dn, input bit bz);
    return {19'd0, v, ia[15:0], wa[15:0], nl, pl, ch[7:0], dn, bz};
  endfunction

  // Reference: decompose the accepted-tap index into mixed-radix coordinates.
  function automatic logic [63:0] model_tap(input int n);
    int kx, ky, ox, oy, ch;
    bit nl, pl;
    kx = n % K;
    ky = (n / K) % K;
    ox = (n / (K * K)) % OUT_W;
    oy = (n / (K * K * OUT_W)) % OUT_H;
    ch = n / (K * K * OUT_W * OUT_H);
    nl = (kx == K - 1) && (ky == K - 1);
    pl = nl && (ox == OUT_W - 1) && (oy == OUT_H - 1);
    return pack((oy + ky) * IMG_W + ox + kx, ch * K * K + ky * K + kx, nl, pl, ch, 1'b1, 1'b0, 1'b1);
  endfunction

  function automatic logic [63:0] dut_tap();
    return {19'd0, addr_valid, in_addr, w_addr, neuron_last, plane_last, out_ch, done, busy};
  endfunction

  task automatic run_walk(input int stall_pct, input int mid_start_at, input int reset_at,
                          input bit record);
    int idx = 0;
    int cyc = 0;
    int pl_cnt = 0;
    bit mid_done = 0;
    bit aborted = 0;
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    stall = ($urandom_range(0, 99) < stall_pct);
    while (idx < TOTAL && cyc < 4 * TOTAL) begin
      @(negedge clk);
      cyc++;
`ifdef CONV_ADDR_CNT_EN
      if (cyc == 1) check("tap_count_after_start", tap_count, 0);
`endif
      check($sformatf("tap%0d", idx), dut_tap(), model_tap(idx));
      if (addr_valid && !stall) begin
        if (record) begin
          rec_in[idx] = int'(in_addr);
          rec_w[idx]  = int'(w_addr);
          rec_nl[idx] = neuron_last;
          rec_pl[idx] = plane_last;
          rec_ch[idx] = int'(out_ch);
        end
        if (plane_last) pl_cnt++;
        idx++;
      end
      if (reset_at > 0 && idx == reset_at) begin
        aborted = 1;
        break;
      end
      if (idx < TOTAL) begin
        @(posedge clk); #1;
        stall = ($urandom_range(0, 99) < stall_pct);
        start = 0;
        if (!mid_done && mid_start_at >= 0 && idx >= mid_start_at) begin
          start = 1;
          mid_done = 1;
        end
      end
    end

    if (aborted) begin
      #1 rst_n = 0;
      #1 check("async_reset_outputs", dut_tap(), 64'd0);
      stall = 0;
      start = 0;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        check("no_done_in_reset", {done, busy, addr_valid}, 3'b000);
      end
      #1 rst_n = 1;
      return;
    end

    check("walk_complete", idx, TOTAL);
    check("plane_last_count", pl_cnt, N_CH);
    @(posedge clk); #1 stall = 0; start = 0;
    @(negedge clk);
    check("end_L1", {addr_valid, neuron_last, plane_last, done, busy}, 5'b00011);
`ifdef CONV_ADDR_CNT_EN
    check("tap_count_at_done", tap_count, TOTAL);
`endif
    @(negedge clk);
    check("end_L2", {done, busy, addr_valid}, 3'b000);
  endtask

  initial begin
    clk   = 0;
    rst_n = 0;
    start = 0;
    stall = 0;

    vecs[0]  = '{0,    0,   0,  0, 0, 0};
    vecs[1]  = '{1,    1,   1,  0, 0, 0};
    vecs[2]  = '{2,    2,   2,  0, 0, 0};
    vecs[3]  = '{3,    3,   3,  0, 0, 0};
    vecs[4]  = '{4,    4,   4,  0, 0, 0};
    vecs[5]  = '{5,    32,  5,  0, 0, 0};
    vecs[6]  = '{6,    33,  6,  0, 0, 0};
    vecs[7]  = '{7,    34,  7,  0, 0, 0};
    vecs[8]  = '{8,    35,  8,  0, 0, 0};
    vecs[9]  = '{9,    36,  9,  0, 0, 0};
    vecs[10] = '{23,   131, 23, 0, 0, 0};
    vecs[11] = '{24,   132, 24, 1, 0, 0};
    vecs[12] = '{25,   1,   0,  0, 0, 0};
    vecs[13] = '{699,  159, 24, 1, 0, 0};
    vecs[14] = '{700,  32,  0,  0, 0, 0};
    vecs[15] = '{1399, 191, 24, 1, 1, 0};
    vecs[16] = '{1400, 0,   25, 0, 0, 1};
    vecs[17] = '{5599, 191, 99, 1, 1, 3};

    repeat (2) @(negedge clk);
    check("reset_outputs", dut_tap(), 64'd0);
`ifdef CONV_ADDR_CNT_EN
    check("reset_tap_count", tap_count, 0);
`endif
    #1 rst_n = 1;

    run_walk(0, -1, 0, 1);
    for (int i = 0; i < NV; i++) begin
      check($sformatf("vec_tap%0d", vecs[i].idx),
            pack(rec_in[vecs[i].idx], rec_w[vecs[i].idx], rec_nl[vecs[i].idx],
                 rec_pl[vecs[i].idx], rec_ch[vecs[i].idx], 1'b0, 1'b0, 1'b0),
            pack(vecs[i].in_a, vecs[i].w_a, vecs[i].nl, vecs[i].pl, vecs[i].ch,
                 1'b0, 1'b0, 1'b0));
    end

    run_walk(30, 300, 0, 0);
    run_walk(0, -1, 500, 0);
    run_walk(20, -1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
